// File: rtl/cheri_tbre_pkg.sv
// -----------------------------------------------------------------------------
// cheri_tbre_pkg
//
// Shared types for the background revocation sweep engine.
//   reg_cap_t    : register-format capability metadata that travels alongside
//                  a 32-bit address word (tag/valid bit plus compressed bounds,
//                  permissions and object type).
//   NULL_REG_CAP : the all-zero, untagged capability.
// -----------------------------------------------------------------------------
package cheri_tbre_pkg;

    typedef struct packed {
        logic       valid;   // capability tag
        logic [8:0] top;     // compressed top bound
        logic [8:0] base;    // compressed base bound
        logic [5:0] cperms;  // compressed permissions
        logic [2:0] otype;   // object type
    } reg_cap_t;

    localparam reg_cap_t NULL_REG_CAP = '0;

endpackage

// File: rtl/cheri_tbre_sweep.sv
// -----------------------------------------------------------------------------
// cheri_tbre_sweep
//
// Background revocation sweep engine. Walks an 8-byte aligned address range,
// loading each capability through the LSU TBRE port, waiting for the verdict
// of the downstream revocation check stage, and storing the capability back
// with its tag cleared whenever the verdict says it is revoked. Exactly one
// LSU request is outstanding at any time.
//
// Optional feature (macro CHERI_TBRE_STATS_EN):
//   defined   -> saturating scan / revoke counters on tbre_scan_cnt_o and
//                tbre_rvk_cnt_o, cleared by an accepted tbre_go_i
//   undefined -> both counter outputs are tied to zero
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   tbre_go_i              start pulse (accepted only while idle)
//   tbre_start_addr_i      first address, bits [2:0] ignored
//   tbre_end_addr_i        exclusive end address, bits [2:0] ignored
//   tbre_busy_o            sweep in progress (any state but IDLE)
//   tbre_done_o            one-cycle completion pulse
//   tbre_err_o             sticky write-back error, cleared on accepted go
//   tbre_lsu_req_o/we_o/addr_o/wdata_o/wcap_o
//                          LSU request; held until tbre_lsu_req_done_i
//   tbre_lsu_req_done_i    LSU accepted the current request
//   lsu_tbre_resp_valid_i/lsu_tbre_resp_err_i/lsu_resp_is_wr_i
//                          LSU response handshake for TBRE requests
//   rf_wdata_lsu_i/rf_wcap_lsu_i
//                          loaded address word and capability metadata
//   tbre_trvk_en_i/tbre_trvk_clrtag_i
//                          revocation verdict from the check stage
//   tbre_scan_cnt_o/tbre_rvk_cnt_o
//                          statistics counters (CntW bits)
// -----------------------------------------------------------------------------
module cheri_tbre_sweep
    import cheri_tbre_pkg::*;
#(
    parameter int unsigned CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            tbre_go_i,
    input  logic [31:0]     tbre_start_addr_i,
    input  logic [31:0]     tbre_end_addr_i,
    output logic            tbre_busy_o,
    output logic            tbre_done_o,
    output logic            tbre_err_o,

    output logic            tbre_lsu_req_o,
    output logic            tbre_lsu_we_o,
    output logic [31:0]     tbre_lsu_addr_o,
    output logic [31:0]     tbre_lsu_wdata_o,
    output reg_cap_t        tbre_lsu_wcap_o,
    input  logic            tbre_lsu_req_done_i,

    input  logic            lsu_tbre_resp_valid_i,
    input  logic            lsu_tbre_resp_err_i,
    input  logic            lsu_resp_is_wr_i,
    input  logic [31:0]     rf_wdata_lsu_i,
    input  reg_cap_t        rf_wcap_lsu_i,

    input  logic            tbre_trvk_en_i,
    input  logic            tbre_trvk_clrtag_i,

    output logic [CntW-1:0] tbre_scan_cnt_o,
    output logic [CntW-1:0] tbre_rvk_cnt_o
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_CHK     = 3'd3;
    localparam logic [2:0] ST_WR_REQ  = 3'd4;
    localparam logic [2:0] ST_WR_WAIT = 3'd5;
    localparam logic [2:0] ST_NEXT    = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    logic [2:0]  state_reg,    state_next;
    logic [31:0] cur_reg,      cur_next;
    logic [31:0] end_reg,      end_next;
    logic [31:0] data_reg,     data_next;
    reg_cap_t    cap_reg,      cap_next;
    logic        load_err_reg, load_err_next;
    logic        err_reg,      err_next;

    // -------------------------------------------------------------------------
    // Decoded events
    // -------------------------------------------------------------------------
    logic [31:0] start_aligned;
    logic [31:0] end_aligned;
    logic        go_accept;
    logic        rd_resp;
    logic        wr_resp;
    logic        chk_exit;
    logic        do_revoke;
    logic [32:0] cur_inc;
    logic        sweep_last;

    // Low address bits are don't-care on both range inputs.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{tbre_start_addr_i[2:0], tbre_end_addr_i[2:0]};

    assign start_aligned = {tbre_start_addr_i[31:3], 3'b000};
    assign end_aligned   = {tbre_end_addr_i[31:3],   3'b000};

    // A go pulse is only honoured in IDLE, so one landing on the DONE cycle
    // is silently dropped.
    assign go_accept = (state_reg == ST_IDLE) && tbre_go_i;

    // Responses are filtered by state and direction; anything arriving in
    // the wrong state (including stragglers after a reset) is ignored.
    assign rd_resp = (state_reg == ST_RD_WAIT) && lsu_tbre_resp_valid_i && !lsu_resp_is_wr_i;
    assign wr_resp = (state_reg == ST_WR_WAIT) && lsu_tbre_resp_valid_i &&  lsu_resp_is_wr_i;

    assign chk_exit  = (state_reg == ST_CHK) && tbre_trvk_en_i;
    // A load that erred never produces a write-back, even if the check stage
    // flags it, since the captured data cannot be trusted.
    assign do_revoke = chk_exit && tbre_trvk_clrtag_i && !load_err_reg;

    // 33-bit increment so a carry out of bit 31 terminates the sweep instead
    // of wrapping back to address 0.
    assign cur_inc    = {1'b0, cur_reg} + 33'd8;
    assign sweep_last = cur_inc[32] || (cur_inc[31:0] >= end_reg);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        end_next      = end_reg;
        data_next     = data_reg;
        cap_next      = cap_reg;
        load_err_next = load_err_reg;
        err_next      = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (tbre_go_i) begin
                    cur_next = start_aligned;
                    end_next = end_aligned;
                    err_next = 1'b0;
                    // Empty (or inverted) range: finish without touching memory.
                    if (start_aligned >= end_aligned) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_RD_REQ;
                    end
                end
            end

            ST_RD_REQ: begin
                if (tbre_lsu_req_done_i) begin
                    state_next = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (rd_resp) begin
                    // Captured unconditionally; the error flag decides later
                    // whether the data may be written back.
                    data_next     = rf_wdata_lsu_i;
                    cap_next      = rf_wcap_lsu_i;
                    load_err_next = lsu_tbre_resp_err_i;
                    state_next    = ST_CHK;
                end
            end

            ST_CHK: begin
                if (tbre_trvk_en_i) begin
                    state_next = do_revoke ? ST_WR_REQ : ST_NEXT;
                end
            end

            ST_WR_REQ: begin
                if (tbre_lsu_req_done_i) begin
                    state_next = ST_WR_WAIT;
                end
            end

            ST_WR_WAIT: begin
                if (wr_resp) begin
                    if (lsu_tbre_resp_err_i) begin
                        err_next = 1'b1;
                    end
                    state_next = ST_NEXT;
                end
            end

            ST_NEXT: begin
                cur_next   = cur_inc[31:0];
                state_next = sweep_last ? ST_DONE : ST_RD_REQ;
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_IDLE;
            cur_reg      <= 32'd0;
            end_reg      <= 32'd0;
            data_reg     <= 32'd0;
            cap_reg      <= NULL_REG_CAP;
            load_err_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cur_reg      <= cur_next;
            end_reg      <= end_next;
            data_reg     <= data_next;
            cap_reg      <= cap_next;
            load_err_reg <= load_err_next;
            err_reg      <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Request fields come straight from registers that only change outside
    // the request states, so they stay stable for the whole grant stall.
    assign tbre_lsu_req_o   = (state_reg == ST_RD_REQ) || (state_reg == ST_WR_REQ);
    assign tbre_lsu_we_o    = (state_reg == ST_WR_REQ);
    assign tbre_lsu_addr_o  = cur_reg;
    assign tbre_lsu_wdata_o = data_reg;

    // Write-back keeps bounds/perms/otype and only drops the tag.
    always_comb begin
        tbre_lsu_wcap_o       = cap_reg;
        tbre_lsu_wcap_o.valid = 1'b0;
    end

    assign tbre_busy_o = (state_reg != ST_IDLE);
    assign tbre_done_o = (state_reg == ST_DONE);
    assign tbre_err_o  = err_reg;

    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
`ifdef CHERI_TBRE_STATS_EN
    // Index 0: capabilities scanned (every CHK exit).
    // Index 1: capabilities revoked (every WR_REQ entry).
    logic [1:0] cnt_inc;
    assign cnt_inc = {do_revoke, chk_exit};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CntW-1:0] cnt_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg <= '0;
                end else if (go_accept) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CntW{1'b1}})) begin
                    // Saturate rather than wrap.
                    cnt_reg <= cnt_reg + CntW'(1);
                end
            end
        end
    endgenerate

    assign tbre_scan_cnt_o = g_cnt[0].cnt_reg;
    assign tbre_rvk_cnt_o  = g_cnt[1].cnt_reg;
`else
    assign tbre_scan_cnt_o = '0;
    assign tbre_rvk_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_cheri_tbre_sweep.sv
// -----------------------------------------------------------------------------
// tb_cheri_tbre_sweep
//
// Directed bench for cheri_tbre_sweep. The bench plays the LSU and the
// revocation check stage. Inputs are driven and outputs sampled just after
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cheri_tbre_sweep;
    import cheri_tbre_pkg::*;

    localparam int CntW = 16;

    logic            clk;
    logic            rst_n;
    logic            go;
    logic [31:0]     start_addr;
    logic [31:0]     end_addr;
    logic            busy;
    logic            done;
    logic            err;
    logic            lsu_req;
    logic            lsu_we;
    logic [31:0]     lsu_addr;
    logic [31:0]     lsu_wdata;
    reg_cap_t        lsu_wcap;
    logic            req_done;
    logic            resp_valid;
    logic            resp_err;
    logic            resp_is_wr;
    logic [31:0]     rf_wdata;
    reg_cap_t        rf_wcap;
    logic            trvk_en;
    logic            trvk_clrtag;
    logic [CntW-1:0] scan_cnt;
    logic [CntW-1:0] rvk_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    cheri_tbre_sweep #(.CntW(CntW)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .tbre_go_i             (go),
        .tbre_start_addr_i     (start_addr),
        .tbre_end_addr_i       (end_addr),
        .tbre_busy_o           (busy),
        .tbre_done_o           (done),
        .tbre_err_o            (err),
        .tbre_lsu_req_o        (lsu_req),
        .tbre_lsu_we_o         (lsu_we),
        .tbre_lsu_addr_o       (lsu_addr),
        .tbre_lsu_wdata_o      (lsu_wdata),
        .tbre_lsu_wcap_o       (lsu_wcap),
        .tbre_lsu_req_done_i   (req_done),
        .lsu_tbre_resp_valid_i (resp_valid),
        .lsu_tbre_resp_err_i   (resp_err),
        .lsu_resp_is_wr_i      (resp_is_wr),
        .rf_wdata_lsu_i        (rf_wdata),
        .rf_wcap_lsu_i         (rf_wcap),
        .tbre_trvk_en_i        (trvk_en),
        .tbre_trvk_clrtag_i    (trvk_clrtag),
        .tbre_scan_cnt_o       (scan_cnt),
        .tbre_rvk_cnt_o        (rvk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CHERI_TBRE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic reg_cap_t mkcap(input logic [3:0] i);
        reg_cap_t c;
        c.valid  = 1'b1;
        c.top    = 9'h100 + 9'(i);
        c.base   = 9'h010 + 9'(i);
        c.cperms = 6'h2A;
        c.otype  = 3'd5;
        return c;
    endfunction

    task automatic start_sweep(input logic [31:0] s, input logic [31:0] e);
        go = 1'b1; start_addr = s; end_addr = e;
        @(negedge clk);
        go = 1'b0;
        $display("[TB] go start=%08h end=%08h", s, e);
    endtask

    // Wait for a request, check it (also across a grant stall), then grant it.
    task automatic grant(input string tag, input logic we, input logic [31:0] addr, input int stall);
        int n = 0;
        while (lsu_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"},  64'(lsu_req),  64'(1'b1));
        check({tag, "_we"},   64'(lsu_we),   64'(we));
        check({tag, "_addr"}, 64'(lsu_addr), 64'(addr));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_req"},  64'(lsu_req),  64'(1'b1));
            check({tag, "_stall_we"},   64'(lsu_we),   64'(we));
            check({tag, "_stall_addr"}, 64'(lsu_addr), 64'(addr));
        end
        req_done = 1'b1;
        @(negedge clk);
        req_done = 1'b0;
        check({tag, "_drop"}, 64'(lsu_req), 64'(1'b0));
        $display("[TB] %s %s addr=%08h stall=%0d", tag, we ? "store" : "load", addr, stall);
    endtask

    task automatic respond(input logic is_wr, input logic e, input logic [31:0] d, input reg_cap_t c);
        resp_valid = 1'b1; resp_is_wr = is_wr; resp_err = e; rf_wdata = d; rf_wcap = c;
        @(negedge clk);
        resp_valid = 1'b0; resp_is_wr = 1'b0; resp_err = 1'b0; rf_wdata = 32'd0; rf_wcap = NULL_REG_CAP;
    endtask

    // Verdict arrives 3 cycles after the load response was sampled.
    task automatic verdict(input logic clr);
        repeat (2) @(negedge clk);
        trvk_en = 1'b1; trvk_clrtag = clr;
        @(negedge clk);
        trvk_en = 1'b0; trvk_clrtag = 1'b0;
    endtask

    task automatic check_store(input string tag, input logic [31:0] d, input reg_cap_t c);
        reg_cap_t exp_cap;
        exp_cap = c;
        exp_cap.valid = 1'b0;
        check({tag, "_wreq"},  64'(lsu_req),   64'(1'b1));
        check({tag, "_wwe"},   64'(lsu_we),    64'(1'b1));
        check({tag, "_wdata"}, 64'(lsu_wdata), 64'(d));
        check({tag, "_wcap"},  64'(lsu_wcap),  64'(exp_cap));
    endtask

    // Wait for done with no request in between, then show a go landing on the
    // done cycle is dropped.
    task automatic wait_done(input string tag);
        int   n = 0;
        logic saw_req = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            if (lsu_req === 1'b1) saw_req = 1'b1;
            @(negedge clk);
            n++;
        end
        check({tag, "_done"},  64'(done),    64'(1'b1));
        check({tag, "_noreq"}, 64'(saw_req), 64'(1'b0));
        go = 1'b1; start_addr = 32'h9000_0000; end_addr = 32'h9000_0100;
        @(negedge clk);
        go = 1'b0;
        check({tag, "_idle_busy"}, 64'(busy), 64'(1'b0));
        check({tag, "_idle_done"}, 64'(done), 64'(1'b0));
        $display("[TB] %s sweep done", tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; go = 1'b0; start_addr = '0; end_addr = '0;
        req_done = 1'b0; resp_valid = 1'b0; resp_err = 1'b0; resp_is_wr = 1'b0;
        rf_wdata = '0; rf_wcap = NULL_REG_CAP; trvk_en = 1'b0; trvk_clrtag = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req",   64'(lsu_req),   64'd0);
        check("rst_we",    64'(lsu_we),    64'd0);
        check("rst_addr",  64'(lsu_addr),  64'd0);
        check("rst_wdata", 64'(lsu_wdata), 64'd0);
        check("rst_wcap",  64'(lsu_wcap),  64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_err",   64'(err),       64'd0);
        check("rst_scan",  64'(scan_cnt),  64'd0);
        check("rst_rvk",   64'(rvk_cnt),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal sweep: 4 loads, verdicts 0,1,0,0, one store at 0x..08
        start_sweep(32'h8000_0000, 32'h8000_0020);
        check("norm_busy", 64'(busy), 64'd1);
        grant("n_ld0", 1'b0, 32'h8000_0000, 0); respond(1'b0, 1'b0, 32'h1234_0000, mkcap(4'd0)); verdict(1'b0);
        grant("n_ld1", 1'b0, 32'h8000_0008, 0); respond(1'b0, 1'b0, 32'h1234_0008, mkcap(4'd1)); verdict(1'b1);
        check_store("n_st1", 32'h1234_0008, mkcap(4'd1));
        grant("n_st1", 1'b1, 32'h8000_0008, 0); respond(1'b1, 1'b0, 32'd0, NULL_REG_CAP);
        grant("n_ld2", 1'b0, 32'h8000_0010, 0); respond(1'b0, 1'b0, 32'h1234_0010, mkcap(4'd2)); verdict(1'b0);
        grant("n_ld3", 1'b0, 32'h8000_0018, 0); respond(1'b0, 1'b0, 32'h1234_0018, mkcap(4'd3)); verdict(1'b0);
        wait_done("norm");
        check("norm_err",  64'(err),      64'd0);
        check("norm_scan", 64'(scan_cnt), STATS ? 64'd4 : 64'd0);
        check("norm_rvk",  64'(rvk_cnt),  STATS ? 64'd1 : 64'd0);

        // Empty range: done on the next cycle, busy for exactly one cycle
        start_sweep(32'h8000_0100, 32'h8000_0100);
        check("empty_done1", 64'(done),    64'd1);
        check("empty_busy1", 64'(busy),    64'd1);
        check("empty_req1",  64'(lsu_req), 64'd0);
        @(negedge clk);
        check("empty_done2", 64'(done),    64'd0);
        check("empty_busy2", 64'(busy),    64'd0);
        check("empty_req2",  64'(lsu_req), 64'd0);

        // Load errors: no store even when clrtag=1 on an erred load
        start_sweep(32'h8000_0200, 32'h8000_0220);
        grant("e_ld0", 1'b0, 32'h8000_0200, 0); respond(1'b0, 1'b0, 32'hAAAA_0000, mkcap(4'd4)); verdict(1'b0);
        grant("e_ld1", 1'b0, 32'h8000_0208, 0); respond(1'b0, 1'b1, 32'hAAAA_0008, mkcap(4'd5)); verdict(1'b0);
        grant("e_ld2", 1'b0, 32'h8000_0210, 0); respond(1'b0, 1'b1, 32'hAAAA_0010, mkcap(4'd6)); verdict(1'b1);
        grant("e_ld3", 1'b0, 32'h8000_0218, 0); respond(1'b0, 1'b0, 32'hAAAA_0018, mkcap(4'd7)); verdict(1'b0);
        wait_done("lerr");
        check("lerr_err",  64'(err),      64'd0);
        check("lerr_scan", 64'(scan_cnt), STATS ? 64'd4 : 64'd0);
        check("lerr_rvk",  64'(rvk_cnt),  STATS ? 64'd0 : 64'd0);

        // Grant stalls and write-back error
        start_sweep(32'h8000_0300, 32'h8000_0308);
        grant("s_ld0", 1'b0, 32'h8000_0300, 5); respond(1'b0, 1'b0, 32'h5555_0300, mkcap(4'd8)); verdict(1'b1);
        check_store("s_st0", 32'h5555_0300, mkcap(4'd8));
        grant("s_st0", 1'b1, 32'h8000_0300, 5); respond(1'b1, 1'b1, 32'd0, NULL_REG_CAP);
        wait_done("stall");
        check("stall_err", 64'(err), 64'd1);

        // Wrap-around: one load at 0xFFFF_FFF0, no wrap; go clears err
        start_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF);
        check("wrap_err_clr", 64'(err),  64'd0);
        check("wrap_busy",    64'(busy), 64'd1);
        grant("w_ld0", 1'b0, 32'hFFFF_FFF0, 0); respond(1'b0, 1'b0, 32'h0BAD_F00D, mkcap(4'd9)); verdict(1'b0);
        wait_done("wrap");

        // Masked start equals masked end: no load
        start_sweep(32'hFFFF_FFF8, 32'hFFFF_FFFF);
        check("wrap2_done", 64'(done),    64'd1);
        check("wrap2_req",  64'(lsu_req), 64'd0);
        @(negedge clk);
        check("wrap2_busy", 64'(busy),    64'd0);

        // Reset while in CHK
        start_sweep(32'h8000_0400, 32'h8000_0410);
        grant("r_ld0", 1'b0, 32'h8000_0400, 0); respond(1'b0, 1'b0, 32'h7777_0400, mkcap(4'd10));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_req",   64'(lsu_req),   64'd0);
        check("mrst_busy",  64'(busy),      64'd0);
        check("mrst_done",  64'(done),      64'd0);
        check("mrst_addr",  64'(lsu_addr),  64'd0);
        check("mrst_wdata", 64'(lsu_wdata), 64'd0);
        check("mrst_wcap",  64'(lsu_wcap),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        trvk_en = 1'b1; trvk_clrtag = 1'b1;
        resp_valid = 1'b1; resp_is_wr = 1'b0;
        @(negedge clk);
        trvk_en = 1'b0; trvk_clrtag = 1'b0; resp_valid = 1'b0;
        check("late_req",  64'(lsu_req), 64'd0);
        check("late_busy", 64'(busy),    64'd0);
        @(negedge clk);
        check("late_req2", 64'(lsu_req), 64'd0);
        $display("[TB] reset mid-sweep applied");

        start_sweep(32'h8000_0500, 32'h8000_0508);
        grant("p_ld0", 1'b0, 32'h8000_0500, 0); respond(1'b0, 1'b0, 32'h6666_0500, mkcap(4'd11)); verdict(1'b0);
        wait_done("post");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
